// File: rtl/wall_follower.sv
// rtl/wall_follower.sv - debounced wall-following controller with minimum rotation and search timeout

module wall_follower_debounce #(
    parameter int DEB_CYCLES = 2,
    parameter int CW         = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] run;

    // run counts consecutive samples disagreeing with the filtered value
    always_ff @(negedge clk) begin
        if (reset) begin
            run  <= '0;
            filt <= 1'b0;
        end else if (raw == filt) begin
            run <= '0;
        end else if (run == DEB_LAST) begin
            filt <= raw;
            run  <= '0;
        end else begin
            run <= run + CW'(1);
        end
    end
endmodule

module wall_follower #(
    parameter int DEB_CYCLES     = 2,
    parameter int ROT_MIN        = 4,
    parameter int SEARCH_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       head,
    input  logic       side,
    input  logic       side_sel,
    output logic       front,
    output logic       rotate,
    output logic       rot_dir,
    output logic       lost,
    output logic [2:0] state
);
    localparam int MAX_A = (ROT_MIN > SEARCH_TIMEOUT) ? ROT_MIN : SEARCH_TIMEOUT;
    localparam int MAX_V = (MAX_A > DEB_CYCLES) ? MAX_A : DEB_CYCLES;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] ROT_LAST = CW'(ROT_MIN - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(SEARCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        FOLLOW  = 3'd2,
        ROTATE  = 3'd3,
        TURN_IN = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic          side_q;
    logic          lost_d;
    logic          h_f;
    logic          s_f;

    wall_follower_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb_head (
        .clk   (clk),
        .reset (reset),
        .raw   (head),
        .filt  (h_f)
    );

    wall_follower_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb_side (
        .clk   (clk),
        .reset (reset),
        .raw   (side),
        .filt  (s_f)
    );

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt     <= '0;
            side_q  <= 1'b0;
            lost    <= 1'b0;
        end else begin
            state_q <= state_d;
            lost    <= lost_d;
            if (state_q == IDLE) begin
                side_q <= side_sel;
            end
            if (state_d != state_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lost_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = SEARCH;
                SEARCH: begin
                    if (h_f) begin
                        state_d = ROTATE;
                    end else if (s_f) begin
                        state_d = FOLLOW;
                    end else if (cnt == TO_LAST) begin
                        state_d = ROTATE;
                        lost_d  = 1'b1;
                    end
                end
                FOLLOW: begin
                    if (h_f) begin
                        state_d = ROTATE;
                    end else if (!s_f) begin
                        state_d = TURN_IN;
                    end
                end
                ROTATE: begin
                    if (cnt >= ROT_LAST && !h_f && s_f) begin
                        state_d = FOLLOW;
                    end
                end
                TURN_IN: begin
                    // an obstacle ahead aborts the turn regardless of the minimum time
                    if (h_f) begin
                        state_d = ROTATE;
                    end else if (cnt >= ROT_LAST) begin
                        state_d = s_f ? FOLLOW : SEARCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        front   = 1'b0;
        rotate  = 1'b0;
        rot_dir = 1'b0;
        case (state_q)
            SEARCH, FOLLOW: front = 1'b1;
            ROTATE: begin
                rotate  = 1'b1;
                rot_dir = ~side_q;
            end
            TURN_IN: begin
                rotate  = 1'b1;
                rot_dir = side_q;
            end
            default: ;
        endcase
    end

    assign state = state_q;
endmodule

// File: tb/tb_wall_follower.sv
// tb/tb_wall_follower.sv - directed and randomized check of wall_follower against a behavioural model

module tb_wall_follower;
    localparam int DEB = 2;
    localparam int RM  = 4;
    localparam int TO  = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       enable   = 1'b0;
    logic       head     = 1'b0;
    logic       side     = 1'b0;
    logic       side_sel = 1'b0;
    logic       front;
    logic       rotate;
    logic       rot_dir;
    logic       lost;
    logic [2:0] state;

    int total  = 0;
    int bad    = 0;
    bit chk_on = 1'b0;

    wall_follower #(.DEB_CYCLES(DEB), .ROT_MIN(RM), .SEARCH_TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .head     (head),
        .side     (side),
        .side_sel (side_sel),
        .front    (front),
        .rotate   (rotate),
        .rot_dir  (rot_dir),
        .lost     (lost),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Model: state, cycles spent in it, latched side, filtered sensors and their disagreement runs
    int m_state = 0;
    int m_age   = 0;
    int m_side  = 0;
    int m_hf    = 0;
    int m_sf    = 0;
    int m_hrun  = 0;
    int m_srun  = 0;
    int m_lost  = 0;

    always @(negedge clk) begin
        int nxt;
        int lp;
        nxt = m_state;
        lp  = 0;
        if (reset) begin
            m_state = 0; m_age = 0; m_side = 0; m_hf = 0; m_sf = 0;
            m_hrun = 0; m_srun = 0; m_lost = 0;
        end else begin
            if (!enable) nxt = 0;
            else begin
                case (m_state)
                    0: nxt = 1;
                    1: if (m_hf == 1) nxt = 3;
                       else if (m_sf == 1) nxt = 2;
                       else if (m_age == TO - 1) begin nxt = 3; lp = 1; end
                    2: if (m_hf == 1) nxt = 3;
                       else if (m_sf == 0) nxt = 4;
                    3: if (m_age >= RM - 1 && m_hf == 0 && m_sf == 1) nxt = 2;
                    4: if (m_hf == 1) nxt = 3;
                       else if (m_age >= RM - 1) nxt = (m_sf == 1) ? 2 : 1;
                    default: nxt = 0;
                endcase
            end
            if (m_state == 0) m_side = int'(side_sel);
            if (nxt != m_state) m_age = 0;
            else if (m_age < 1000) m_age = m_age + 1;
            m_state = nxt;
            m_lost  = lp;
            if (int'(head) != m_hf) begin
                m_hrun++;
                if (m_hrun == DEB) begin m_hf = int'(head); m_hrun = 0; end
            end else m_hrun = 0;
            if (int'(side) != m_sf) begin
                m_srun++;
                if (m_srun == DEB) begin m_sf = int'(side); m_srun = 0; end
            end else m_srun = 0;
        end
    end

    always @(posedge clk) begin
        int ef;
        int er;
        int ed;
        if (chk_on) begin
            ef = (m_state == 1 || m_state == 2) ? 1 : 0;
            er = (m_state == 3 || m_state == 4) ? 1 : 0;
            ed = (m_state == 3) ? 1 - m_side : (m_state == 4) ? m_side : 0;
            chk("model_state", 32'(state), m_state);
            chk("model_front", 32'(front), ef);
            chk("model_rotate", 32'(rotate), er);
            chk("model_rot_dir", 32'(rot_dir), ed);
            chk("model_lost", 32'(lost), m_lost);
        end
    end

    initial begin
        int mode;
        tick();
        tick();
        chk_on = 1'b1;
        chk("rst_state", 32'(state), 0);
        chk("rst_front", 32'(front), 0);
        chk("rst_rotate", 32'(rotate), 0);
        chk("rst_rot_dir", 32'(rot_dir), 0);
        chk("rst_lost", 32'(lost), 0);
        reset = 1'b0;

        // search timeout
        enable = 1'b1;
        tick();
        chk("to_search", 32'(state), 1);
        repeat (15) tick();
        chk("to_still_search", 32'(state), 1);
        tick();
        chk("to_rotate", 32'(state), 3);
        chk("to_lost", 32'(lost), 1);
        tick();
        chk("to_lost_clear", 32'(lost), 0);

        // wall appears during rotation
        side = 1'b1;
        tick(); tick();
        chk("rw_wait", 32'(state), 3);
        tick();
        chk("rw_follow", 32'(state), 2);
        chk("rw_front", 32'(front), 1);

        // obstacle while following the left wall
        head = 1'b1;
        tick(); tick();
        chk("ob_wait", 32'(state), 2);
        tick();
        chk("ob_rotate", 32'(state), 3);
        chk("ob_rot_dir", 32'(rot_dir), 1);
        head = 1'b0;
        repeat (3) tick();
        chk("ob_min_rot", 32'(state), 3);
        tick();
        chk("ob_follow", 32'(state), 2);

        // right wall lost: turn in, then search
        enable = 1'b0; side_sel = 1'b1;
        tick();
        chk("ti_idle", 32'(state), 0);
        tick();
        enable = 1'b1;
        tick();
        chk("ti_search", 32'(state), 1);
        tick();
        chk("ti_follow", 32'(state), 2);
        side = 1'b0;
        tick(); tick();
        chk("ti_wait", 32'(state), 2);
        tick();
        chk("ti_turn_in", 32'(state), 4);
        chk("ti_rot_dir", 32'(rot_dir), 1);
        side_sel = 1'b0;
        tick(); tick();
        chk("ti_side_held", 32'(rot_dir), 1);
        tick();
        chk("ti_min_rot", 32'(state), 4);
        tick();
        chk("ti_to_search", 32'(state), 1);

        // turn-in aborted by an obstacle
        side = 1'b1;
        repeat (3) tick();
        chk("ab_follow", 32'(state), 2);
        side = 1'b0;
        repeat (3) tick();
        chk("ab_turn_in", 32'(state), 4);
        head = 1'b1;
        tick(); tick();
        chk("ab_wait", 32'(state), 4);
        tick();
        chk("ab_rotate", 32'(state), 3);
        chk("ab_rot_dir", 32'(rot_dir), 0);

        // back to follow, then a one-sample head glitch
        head = 1'b0; side = 1'b1;
        repeat (3) tick();
        chk("gl_rotating", 32'(state), 3);
        tick();
        chk("gl_follow", 32'(state), 2);
        head = 1'b1;
        tick();
        head = 1'b0;
        repeat (4) tick();
        chk("gl_reject", 32'(state), 2);

        // enable drop during rotation
        head = 1'b1;
        repeat (3) tick();
        chk("en_rotate", 32'(state), 3);
        enable = 1'b0;
        tick();
        chk("en_idle", 32'(state), 0);
        chk("en_front", 32'(front), 0);
        chk("en_rotate_out", 32'(rotate), 0);
        chk("en_rot_dir", 32'(rot_dir), 0);

        // reset during turn-in
        head = 1'b0; enable = 1'b1;
        repeat (8) tick();
        chk("rs_follow", 32'(state), 2);
        side = 1'b0;
        repeat (3) tick();
        chk("rs_turn_in", 32'(state), 4);
        reset = 1'b1;
        tick();
        chk("rs_state", 32'(state), 0);
        chk("rs_rotate", 32'(rotate), 0);
        chk("rs_rot_dir", 32'(rot_dir), 0);
        reset = 1'b0;

        // search to follow latency
        tick();
        chk("sf_search", 32'(state), 1);
        side = 1'b1;
        tick(); tick();
        chk("sf_wait", 32'(state), 1);
        tick();
        chk("sf_follow", 32'(state), 2);
        chk("sf_front", 32'(front), 1);

        // obstacle at the timeout edge: rotate without lost
        reset = 1'b1; side = 1'b0; head = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        repeat (13) tick();
        head = 1'b1;
        tick(); tick();
        chk("tl_search", 32'(state), 1);
        tick();
        chk("tl_rotate", 32'(state), 3);
        chk("tl_no_lost", 32'(lost), 0);
        head = 1'b0;

        for (int seg = 0; seg < 60; seg++) begin
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 64; c++) begin
                reset    = ($urandom_range(0, 199) == 0);
                enable   = ($urandom_range(0, 39) != 0);
                side_sel = 1'($urandom_range(0, 1));
                if (mode == 1) begin
                    head = 1'b0;
                    side = 1'b0;
                end else begin
                    if ($urandom_range(0, 7) == 0) head = ~head;
                    if ($urandom_range(0, 5) == 0) side = ~side;
                end
                tick();
            end
        end

        @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wall_follower.md
# wall_follower

Parametrised successor to the robot's single-side Mealy controller. It filters the two wall sensors, follows a wall on a selectable side, and enforces a minimum rotation time. It also turns back toward a lost wall and escapes endless searching with a timeout. It sits between the raw sensor inputs and the motor driver, which consumes `front`, `rotate` and `rot_dir`.

## Interface
- `DEB_CYCLES`, default 2: consecutive identical samples needed before a filtered sensor changes (≥1).
- `ROT_MIN`, default 4: minimum cycles spent in ROTATE or TURN_IN before that state may exit (≥1).
- `SEARCH_TIMEOUT`, default 16: cycles in SEARCH with no wall seen before a forced rotation (≥2).
- Derived, not user-set: counter width `CW` = $clog2(max(ROT_MIN, SEARCH_TIMEOUT, DEB_CYCLES)+1).

Ports:
- `clk`  in  1  single clock; all state updates on the falling edge, consistent with the robot controllers.
- `reset`  in  1  synchronous, active-high; sampled on the same edge.
- `enable`  in  1  run request; 0 forces IDLE.
- `head`  in  1  raw front obstacle sensor.
- `side`  in  1  raw wall sensor on the followed side.
- `side_sel`  in  1  wall side: 0 = left, 1 = right; latched only in IDLE.
- `front`  out  1  drive forward.
- `rotate`  out  1  rotate in place.
- `rot_dir`  out  1  0 = counter-clockwise (left turn), 1 = clockwise (right turn).
- `lost`  out  1  one-cycle pulse on a search timeout.
- `state`  out  3  current state code.

## Operation
- **Debounce.** One filter per sensor produces `h_f` and `s_f`.
  - A per-input counter increments while the raw value differs from the filtered value, and clears when they match.
  - The filtered value flips at the edge where the counter reaches DEB_CYCLES; the counter then clears.
- **State codes:** IDLE=0, SEARCH=1, FOLLOW=2, ROTATE=3, TURN_IN=4. Codes 5–7 are illegal and go to IDLE on the next edge.
- **Side latch.** `side_q` is loaded from `side_sel` on every edge while in IDLE. It is held constant in all other states.
- **Transitions.** Each is evaluated with `h_f`/`s_f` as held before the edge. Priority: `reset` > `enable`=0 > the rules below.
  - IDLE: go to SEARCH when `enable`=1.
  - SEARCH:
    - `h_f`=1 → ROTATE.
    - `h_f`=0, `s_f`=1 → FOLLOW.
    - Both 0: stay and increment `cnt`.
    - At `cnt` = SEARCH_TIMEOUT−1 with both still 0 → ROTATE and pulse `lost`.
  - FOLLOW:
    - `h_f`=0, `s_f`=1: stay.
    - `h_f`=1 → ROTATE.
    - `h_f`=0, `s_f`=0 → TURN_IN.
  - ROTATE: `cnt` increments each cycle. Once `cnt` ≥ ROT_MIN−1:
    - `h_f`=0, `s_f`=1 → FOLLOW.
    - Any other combination: stay, with `cnt` saturating.
  - TURN_IN:
    - `h_f`=1 → ROTATE immediately, regardless of `cnt`.
    - Else, at `cnt` ≥ ROT_MIN−1: `s_f`=1 → FOLLOW, else → SEARCH.
- **Counter.** `cnt` clears on every state change and saturates at its maximum.
- **Outputs.** Decoded from the registered state only (Moore); `lost` is registered.
  - IDLE: `front`=0, `rotate`=0.
  - SEARCH and FOLLOW: `front`=1, `rotate`=0.
  - ROTATE: `front`=0, `rotate`=1, `rot_dir` = ~`side_q` (turn away from the wall).
  - TURN_IN: `front`=0, `rotate`=1, `rot_dir` = `side_q` (turn toward the wall).
  - `rot_dir` = 0 when `rotate`=0.

## Timing
- **Reset values:** `state`=IDLE, `front`=0, `rotate`=0, `rot_dir`=0, `lost`=0. Filters, counters and `side_q` are all 0.
- **Reset mid-operation:** reset from any state takes effect at the sampling edge. Outputs are at reset values from that edge on.
- **Sensor to state latency:** a raw change held stable updates `h_f`/`s_f` at the DEB_CYCLES-th sampling edge. The state changes one edge later, so the total is DEB_CYCLES+1 falling edges.
- **Glitch rejection:** a raw pulse shorter than DEB_CYCLES samples never changes the filtered value.
- **Simultaneous events:**
  - `enable` falling together with any transition condition: IDLE wins.
  - `h_f`=1 at the timeout edge: ROTATE is entered without `lost`.
- **`lost`:** high for exactly one cycle, the cycle after the timeout edge.
- **Minimum rotation:** ROTATE and TURN_IN last at least ROT_MIN cycles, except TURN_IN aborted by `h_f`=1.

## Test plan
Defaults: DEB_CYCLES=2, ROT_MIN=4, SEARCH_TIMEOUT=16.
- Reset then `enable`=1, `head`=`side`=0 → SEARCH at the next edge. 16 cycles later `state`=3 and `lost`=1 for one cycle.
- In SEARCH, `side`=1 held → `s_f` rises at the 2nd edge and `state`=2 at the 3rd, with `front`=1.
- In FOLLOW with `side_sel` latched 0, `head`=1 → ROTATE with `rot_dir`=1.
  - `head`=0 and `side`=1 filtered after 1 cycle → still ROTATE until 4 cycles, then FOLLOW.
- In FOLLOW with `side_sel`=1, `side`=0 → TURN_IN with `rot_dir`=1.
  - `side` stays 0 → SEARCH after 4 cycles.
  - Repeat with `head`=1 at cycle 2 → ROTATE immediately.
- 1-cycle `head` glitch in FOLLOW → `state` stays 2. Toggling `side_sel` outside IDLE → `rot_dir` unchanged.
- `enable`=0 during ROTATE → IDLE next edge with all outputs 0. `reset`=1 during TURN_IN → IDLE the same edge.
